// File: rtl/jk_pattern_sequencer.sv
// Pattern sequencer for a 4-bit JK LED stage: converts a prescaled tick or a debounced manual
// step into one-cycle J/K pulses that move a shadowed downstream register through a pattern.
module jk_pattern_sequencer #(
    parameter int unsigned TICK_DIV  = 12000000,
    parameter int unsigned DB_CYCLES = 120000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_run_i,
    input  logic       btn_step_i,
    input  logic [1:0] mode_i,
    output logic       j1_o,
    output logic       j2_o,
    output logic       j3_o,
    output logic       j4_o,
    output logic       k1_o,
    output logic       k2_o,
    output logic       k3_o,
    output logic       k4_o,
    output logic       tick_o,
    output logic       running_o
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DbMax    = DW'(DB_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Bit 0 = run button, bit 1 = step button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    db_q, db_d, db_prev_q;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];
    logic          run_press, step_press;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          upd_req;

    logic [3:0]    shadow_q, shadow_d;
    logic          dir_q, dir_d;
    logic          resync_q, resync_d;
    logic [3:0]    j_q, j_d, k_q, k_d;
    logic [3:0]    nxt;
    logic          dir_nxt;

    assign btn_raw = {btn_step_i, btn_run_i};

    // The level only follows the synced input after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            db_d[b]     = db_q[b];
            db_cnt_d[b] = '0;
            if (sync2_q[b] != db_q[b]) begin
                if (db_cnt_q[b] == DbMax) begin
                    db_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DW'(1);
                end
            end
        end
    end

    assign run_press  = db_q[0] & ~db_prev_q[0];
    assign step_press = db_q[1] & ~db_prev_q[1];

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        upd_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_press) begin
                    state_d = StRun;
                    presc_d = '0;
                end else if (step_press) begin
                    upd_req = 1'b1;
                end
            end
            StRun: begin
                if (run_press) begin
                    state_d = StIdle;
                    presc_d = '0;
                end else if (presc_q == PrescMax) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    upd_req = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        endcase
    end

    always_comb begin
        nxt     = shadow_q;
        dir_nxt = dir_q;
        unique case (mode_i)
            2'b00: nxt = shadow_q + 4'd1;
            2'b01: nxt = (shadow_q == 4'b0000) ? 4'b0001 : {shadow_q[2:0], shadow_q[3]};
            2'b10: begin
                if (!$onehot(shadow_q)) begin
                    nxt     = 4'b0001;
                    dir_nxt = 1'b0;
                end else if (!dir_q) begin
                    if (shadow_q[3]) begin
                        nxt     = 4'b0100;
                        dir_nxt = 1'b1;
                    end else begin
                        nxt = shadow_q << 1;
                    end
                end else begin
                    if (shadow_q[0]) begin
                        nxt     = 4'b0010;
                        dir_nxt = 1'b0;
                    end else begin
                        nxt = shadow_q >> 1;
                    end
                end
            end
            default: nxt = ~shadow_q;
        endcase
    end

    always_comb begin
        j_d      = 4'b0000;
        k_d      = 4'b0000;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        resync_d = resync_q;
        if (upd_req) begin
            shadow_d = nxt;
            dir_d    = dir_nxt;
            if (resync_q) begin
                // Downstream contents unknown: force every bit, no holds.
                j_d      = nxt;
                k_d      = ~nxt;
                resync_d = 1'b0;
            end else begin
                j_d = nxt & ~shadow_q;
                k_d = ~nxt & shadow_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            db_q      <= 2'b00;
            db_prev_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
            end
            state_q   <= StIdle;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            shadow_q  <= 4'b0000;
            dir_q     <= 1'b0;
            resync_q  <= 1'b1;
            j_q       <= 4'b0000;
            k_q       <= 4'b0000;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
            end
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            shadow_q  <= shadow_d;
            dir_q     <= dir_d;
            resync_q  <= resync_d;
            j_q       <= j_d;
            k_q       <= k_d;
        end
    end

    assign j1_o      = j_q[0];
    assign j2_o      = j_q[1];
    assign j3_o      = j_q[2];
    assign j4_o      = j_q[3];
    assign k1_o      = k_q[0];
    assign k2_o      = k_q[1];
    assign k3_o      = k_q[2];
    assign k4_o      = k_q[3];
    assign tick_o    = tick_q;
    assign running_o = (state_q == StRun);

endmodule

// File: tb/tb_jk_pattern_sequencer.sv
// Directed bench for jk_pattern_sequencer: expected J/K pulses are queued with each stimulus
// step and matched by a negedge monitor as the DUT emits them.
module tb_jk_pattern_sequencer;

    localparam int TickDiv  = 4;
    localparam int DbCycles = 3;

    logic       clk = 1'b0;
    logic       rst, btn_run, btn_step;
    logic [1:0] mode;
    logic       j1, j2, j3, j4, k1, k2, k3, k4, tick, running;
    logic [7:0] jk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_tick = -1;
    int n_ticks  = 0;
    int n_pulses = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [3:0] sh;

    jk_pattern_sequencer #(
        .TICK_DIV (TickDiv),
        .DB_CYCLES(DbCycles)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_run_i (btn_run),
        .btn_step_i(btn_step),
        .mode_i    (mode),
        .j1_o      (j1),
        .j2_o      (j2),
        .j3_o      (j3),
        .j4_o      (j4),
        .k1_o      (k1),
        .k2_o      (k2),
        .k3_o      (k3),
        .k4_o      (k4),
        .tick_o    (tick),
        .running_o (running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign jk = {j4, j3, j2, j1, k4, k3, k2, k1};

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_checks++;
        assert (got === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic checkint(input string tag, input int got, input int expv);
        n_checks++;
        assert (got == expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Monitor: every nonzero J/K cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (jk !== 8'h00) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check8("unexpected_pulse", jk, 8'h00);
            end else begin
                mon_exp = exp_q.pop_front();
                check8("pulse", jk, mon_exp);
                if (running === 1'b1) check8("tick_with_pulse", {7'd0, tick}, 8'h01);
            end
        end
        if (tick === 1'b1) begin
            n_ticks++;
            check8("tick_only_running", {7'd0, running}, 8'h01);
            if (last_tick >= 0) checkint("tick_period", cyc - last_tick, TickDiv);
            last_tick = cyc;
        end
        if (running !== 1'b1) last_tick = -1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue the pulse that moving the shadow to nxt must produce.
    task automatic push(input logic [3:0] nxt, input logic resync);
        logic [3:0] j, k;
        j = resync ? nxt : (nxt & ~sh);
        k = resync ? ~nxt : (~nxt & sh);
        exp_q.push_back({j, k});
        sh = nxt;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkint(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic press_step(input int hold);
        btn_step = 1'b1;
        cycles(hold);
        btn_step = 1'b0;
        cycles(10);
    endtask

    initial begin
        int w;
        int t0;
        int p0;
        logic seen;
        rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; mode = 2'b00; sh = 4'b0000;
        cycles(3);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check8("idle_jk", jk, 8'h00);
            check8("idle_tick_running", {6'd0, tick, running}, 8'h00);
        end

        // First update after reset drives all four bits.
        mode = 2'b00;
        push(4'b0001, 1'b1);
        press_step(6);
        drain("step1_done");
        push(4'b0010, 1'b0);
        press_step(6);
        drain("step2_done");

        // Ring in RUN: six ticks walk 0010 round to 1000, then stop.
        mode = 2'b01;
        push(4'b0100, 1'b0);
        push(4'b1000, 1'b0);
        push(4'b0001, 1'b0);
        push(4'b0010, 1'b0);
        push(4'b0100, 1'b0);
        push(4'b1000, 1'b0);
        n_ticks = 0;
        btn_run = 1'b1;
        w = 0;
        while (running !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        check8("run_start", {7'd0, running}, 8'h01);
        t0 = cyc;
        btn_run = 1'b0;
        cycles(20);
        btn_run = 1'b1;
        cycles(6);
        btn_run = 1'b0;
        w = 0;
        while (running !== 1'b0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        check8("run_stop", {7'd0, running}, 8'h00);
        cycles(16);
        checkint("tick_count", n_ticks, 6);
        checkint("run_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        check8("stopped_tick_running", {6'd0, tick, running}, 8'h00);

        // Ping-pong bounce from 1000 going up.
        mode = 2'b10;
        push(4'b0100, 1'b0); press_step(6); drain("pp1");
        push(4'b0010, 1'b0); press_step(6); drain("pp2");
        push(4'b0001, 1'b0); press_step(6); drain("pp3");
        push(4'b0010, 1'b0); press_step(6); drain("pp4");

        // Short glitch is filtered, a solid press gives exactly one update.
        mode = 2'b00;
        p0 = n_pulses;
        press_step(2);
        checkint("glitch_no_update", n_pulses - p0, 0);
        push(4'b0011, 1'b0);
        p0 = n_pulses;
        press_step(6);
        drain("held_done");
        checkint("held_one_update", n_pulses - p0, 1);

        // Reset landing on a live pulse.
        mode = 2'b11;
        push(4'b1100, 1'b0);
        btn_step = 1'b1;
        seen = 1'b0;
        w = 0;
        while (!seen && w < 30) begin
            @(negedge clk);
            if (jk !== 8'h00) seen = 1'b1;
            w++;
        end
        check8("rst_pulse_seen", {7'd0, seen}, 8'h01);
        rst = 1'b1;
        btn_step = 1'b0;
        cycles(1);
        check8("rst_mid_jk", jk, 8'h00);
        check8("rst_mid_tick_running", {6'd0, tick, running}, 8'h00);
        rst = 1'b0;
        exp_q.delete();
        sh = 4'b0000;
        cycles(10);
        mode = 2'b00;
        push(4'b0001, 1'b1);
        press_step(6);
        drain("post_rst_resync");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
